fft8_twiddle_scheduler: RTL and testbench
=========================================

Name: fft8_twiddle_scheduler

Overview:
Sequences one radix-2 DIT 8-point FFT, 3 stages of 4 butterflies each. Per butterfly it generates the operand index pair and the twiddle ROM address. It presents each butterfly to the butterfly datapath with a valid/ready handshake, aligned to the 1-cycle registered twiddle ROM output. It enforces a stage barrier: stage s+1 issues only after all 4 stage-s results are written back.

Parameters:
DRAIN_TIMEOUT, 64, max cycles in DRAIN waiting for writebacks before abort (range 1..255)
MAX_OUT, 4, max accepted-but-not-written-back butterflies; fixed at 4 (one stage)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle request to run one FFT; ignored while busy=1
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse on normal completion
err  out  1  1-cycle pulse on stray writeback or drain timeout
tw_addr  out  2  twiddle ROM address (combinational); ROM returns data one clock later
bf_valid  out  1  butterfly descriptor valid (registered)
bf_ready  in  1  butterfly accepts descriptor when bf_valid and bf_ready are both high
bf_idx_a  out  3  upper operand index (registered)
bf_idx_b  out  3  lower operand index, always bf_idx_a + span (registered)
bf_stage  out  2  stage number 0..2 (registered)
wb_valid  in  1  1-cycle pulse per butterfly result written back

Behaviour:
- Reset (async): state=IDLE; busy, done, err, bf_valid = 0; bf_idx_a, bf_idx_b, bf_stage = 0; tw_addr = 0; stage and butterfly counters = 0; outstanding = 0; timeout counter = 0.
- Index math for stage s (0..2), butterfly b (0..3), span = 1<<s:
  - idx_a = ((b>>s)<<(s+1)) | (b & (span-1))
  - idx_b = idx_a + span
  - k = (b & (span-1)) << (2-s)
- States:
  - IDLE: start=1 -> ISSUE, with s=0, b=0, busy=1.
  - ISSUE: loads descriptors into the bf_* output registers, one per accepted handshake.
    - Descriptor register loads when bf_valid=0 or bf_ready=1.
    - After the 4th descriptor of a stage is accepted, bf_valid drops and the state goes to DRAIN.
    - No descriptor of the next stage is issued before DRAIN exits.
  - DRAIN: waits for outstanding==0.
    - If s<2: s++, b=0, -> ISSUE.
    - If s=2: -> DONE.
    - The timeout counter resets on entry and counts every DRAIN cycle. Reaching DRAIN_TIMEOUT: err pulse, -> IDLE, busy=0, no done.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- Twiddle alignment: tw_addr always equals k of the descriptor that will sit in the bf_* registers after the next rising edge.
  - During a stall (bf_valid=1, bf_ready=0), tw_addr holds k of the current descriptor, so the ROM output stays valid and stable.
  - In IDLE and DRAIN, tw_addr = 0.
- Latency: start accepted at edge E0 -> bf_valid=1 with the first descriptor after E1. With bf_ready tied high, 4 consecutive descriptors follow per stage.
- Outstanding counter (0..4):
  - +1 on handshake, -1 on wb_valid; simultaneous events give a net 0.
  - wb_valid with outstanding=0 and no same-cycle handshake: err pulse, count stays 0.
  - wb_valid in IDLE: err pulse, otherwise ignored.
- bf_* outputs hold their last values when bf_valid=0.
- start during busy is ignored with no error. start in the same cycle as the DONE state is also ignored; a new run needs start in IDLE.
- Assertion of rst mid-run immediately returns to IDLE with all outputs at reset values; no done and no err.

Test Plan:
- Full run, bf_ready=1, wb_valid fixed 2 cycles after each handshake -> descriptors (a,b,k) in order:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - ROM w_real/w_imag at each handshake matches k: 0 -> 3F800000/00000000; 1 -> 3F3504F3/BF3504F3; 2 -> 00000000/BF800000; 3 -> BF3504F3/BF3504F3.
  - done pulses once; busy=0 afterwards.
- Backpressure: bf_ready low for 3 cycles on stage 2, butterfly 1 -> bf_idx_a=1, bf_idx_b=5, tw_addr=1 and ROM output 3F3504F3/BF3504F3 all held stable; no descriptor skipped or duplicated.
- Stage barrier: withhold the 4th stage-0 writeback for 10 cycles -> no stage-1 bf_valid until 1 cycle after that wb_valid; bf_stage=1 on resume.
- Timeout: DRAIN_TIMEOUT=8, omit one stage-1 writeback -> err pulses once after 8 DRAIN cycles; busy=0; done never asserted.
- Stray writeback: wb_valid in IDLE -> err 1-cycle pulse, state unchanged. Simultaneous handshake and wb_valid -> outstanding unchanged.
- Reset mid stage 1 (after 2 handshakes) -> all outputs 0 asynchronously. A subsequent start reproduces the full stage-0 sequence.

Source files
------------

// File: rtl/fft8_twiddle_scheduler_if.sv
// Butterfly descriptor handshake, twiddle ROM address and writeback strobe between
// the 8-point FFT scheduler (master) and the butterfly datapath (slave).
interface fft8_twiddle_scheduler_if;
    logic       bf_valid;
    logic       bf_ready;
    logic [2:0] bf_idx_a;
    logic [2:0] bf_idx_b;
    logic [1:0] bf_stage;
    logic [1:0] tw_addr;
    logic       wb_valid;

    modport master (
        output bf_valid, bf_idx_a, bf_idx_b, bf_stage, tw_addr,
        input  bf_ready, wb_valid
    );

    modport slave (
        input  bf_valid, bf_idx_a, bf_idx_b, bf_stage, tw_addr,
        output bf_ready, wb_valid
    );
endinterface

// File: rtl/fft8_twiddle_scheduler.sv
// Issues the 12 butterflies of a radix-2 DIT 8-point FFT, one stage at a time, with
// tw_addr leading the registered descriptor by one clock to match the twiddle ROM.
module fft8_twiddle_scheduler #(
    parameter int DRAIN_TIMEOUT = 64,
    parameter int MAX_OUT       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    fft8_twiddle_scheduler_if.master bf
);
    localparam int         OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [7:0] TMO   = 8'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       stage_q, stage_d;
    logic [2:0]       bfly_q, bfly_d;
    logic             bf_valid_q, bf_valid_d;
    logic [2:0]       idx_a_q, idx_a_d;
    logic [2:0]       idx_b_q, idx_b_d;
    logic [1:0]       bf_stage_q, bf_stage_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             err_q, err_d;

    logic       hs, wb_take, load;
    logic [1:0] ld_stage, ld_bfly;
    logic [1:0] tw_addr_c;

    function automatic logic [2:0] calc_idx_a(input logic [1:0] s, input logic [1:0] b);
        case (s)
            2'd0:    calc_idx_a = {b, 1'b0};
            2'd1:    calc_idx_a = {b[1], 1'b0, b[0]};
            default: calc_idx_a = {1'b0, b};
        endcase
    endfunction

    // Also valid on idx_a[1:0], whose low s bits equal b & (span-1).
    function automatic logic [1:0] calc_k(input logic [1:0] s, input logic [1:0] b);
        case (s)
            2'd0:    calc_k = 2'd0;
            2'd1:    calc_k = {b[0], 1'b0};
            default: calc_k = b;
        endcase
    endfunction

    assign hs      = bf_valid_q & bf.bf_ready;
    assign wb_take = bf.wb_valid & ((outst_q != '0) | hs);

    // NOTE: every _d gets a default before the case so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        bfly_d     = bfly_q;
        bf_valid_d = bf_valid_q;
        idx_a_d    = idx_a_q;
        idx_b_d    = idx_b_q;
        bf_stage_d = bf_stage_q;
        tmo_d      = tmo_q;
        err_d      = bf.wb_valid & ~wb_take;
        outst_d    = outst_q;
        load       = 1'b0;
        ld_stage   = stage_q;
        ld_bfly    = bfly_q[1:0];

        if (hs && !wb_take)      outst_d = outst_q + 1'b1;
        else if (!hs && wb_take) outst_d = outst_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    stage_d = 2'd0;
                    bfly_d  = 3'd0;
                end
            end
            S_ISSUE: begin
                if (!bf_valid_q || bf.bf_ready) begin
                    if (bfly_q != 3'd4) begin
                        load = 1'b1;
                    end else begin
                        bf_valid_d = 1'b0;
                        tmo_d      = 8'd0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leaving the barrier loads butterfly 0 of the next stage directly (its k is 0).
                if (outst_d == '0) begin
                    if (stage_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d  = stage_q + 2'd1;
                        ld_stage = stage_q + 2'd1;
                        ld_bfly  = 2'd0;
                        load     = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end else if (tmo_q + 8'd1 == TMO) begin
                    err_d   = 1'b1;
                    outst_d = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            bf_valid_d = 1'b1;
            idx_a_d    = calc_idx_a(ld_stage, ld_bfly);
            idx_b_d    = idx_a_d + (3'd1 << ld_stage);
            bf_stage_d = ld_stage;
            bfly_d     = {1'b0, ld_bfly} + 3'd1;
        end
    end

    always_comb begin
        busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
        if (load)                    tw_addr_c = calc_k(ld_stage, ld_bfly);
        else if (state_q == S_ISSUE) tw_addr_c = calc_k(bf_stage_q, idx_a_q[1:0]);
        else                         tw_addr_c = 2'd0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            stage_q    <= 2'd0;
            bfly_q     <= 3'd0;
            bf_valid_q <= 1'b0;
            idx_a_q    <= 3'd0;
            idx_b_q    <= 3'd0;
            bf_stage_q <= 2'd0;
            outst_q    <= '0;
            tmo_q      <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            bfly_q     <= bfly_d;
            bf_valid_q <= bf_valid_d;
            idx_a_q    <= idx_a_d;
            idx_b_q    <= idx_b_d;
            bf_stage_q <= bf_stage_d;
            outst_q    <= outst_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign err         = err_q;
    assign bf.bf_valid = bf_valid_q;
    assign bf.bf_idx_a = idx_a_q;
    assign bf.bf_idx_b = idx_b_q;
    assign bf.bf_stage = bf_stage_q;
    assign bf.tw_addr  = tw_addr_c;
endmodule

// File: tb/tb_fft8_twiddle_scheduler.sv
// Scoreboard bench for fft8_twiddle_scheduler: expected descriptors are queued at start,
// a negedge monitor checks each handshake against them and schedules writebacks.
module tb_fft8_twiddle_scheduler;
    typedef struct {
        int a;
        int b;
        int k;
        int s;
    } desc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic bf_ready = 1'b1;
    logic wb_valid = 1'b0;
    logic wb_force = 1'b0;
    logic busy_n, done_n, err_n, busy_t, done_t, err_t;
    logic sel = 1'b0;

    fft8_twiddle_scheduler_if bus_n ();
    fft8_twiddle_scheduler_if bus_t ();

    assign bus_n.bf_ready = bf_ready;
    assign bus_n.wb_valid = wb_valid;
    assign bus_t.bf_ready = bf_ready;
    assign bus_t.wb_valid = wb_valid;

    fft8_twiddle_scheduler #(.DRAIN_TIMEOUT(64), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy_n), .done(done_n), .err(err_n), .bf(bus_n)
    );

    fft8_twiddle_scheduler #(.DRAIN_TIMEOUT(8), .MAX_OUT(4)) dut_t (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy_t), .done(done_t), .err(err_t), .bf(bus_t)
    );

    always #5 clk = ~clk;

    logic       m_busy, m_done, m_err, m_valid;
    logic [2:0] m_a, m_b;
    logic [1:0] m_stage, m_tw;

    always_comb begin
        if (sel) begin
            m_busy = busy_t; m_done = done_t; m_err = err_t; m_valid = bus_t.bf_valid;
            m_a = bus_t.bf_idx_a; m_b = bus_t.bf_idx_b; m_stage = bus_t.bf_stage; m_tw = bus_t.tw_addr;
        end else begin
            m_busy = busy_n; m_done = done_n; m_err = err_n; m_valid = bus_n.bf_valid;
            m_a = bus_n.bf_idx_a; m_b = bus_n.bf_idx_b; m_stage = bus_n.bf_stage; m_tw = bus_n.tw_addr;
        end
    end

    function automatic logic [63:0] rom_lookup(input logic [1:0] k);
        case (k)
            2'd0:    rom_lookup = 64'h3F800000_00000000;
            2'd1:    rom_lookup = 64'h3F3504F3_BF3504F3;
            2'd2:    rom_lookup = 64'h00000000_BF800000;
            default: rom_lookup = 64'hBF3504F3_BF3504F3;
        endcase
    endfunction

    logic [63:0] rom_q = 64'd0;
    always @(posedge clk) rom_q <= rom_lookup(m_tw);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    desc_t exp_q[$];
    int    wb_q[$];
    desc_t cur;
    int hs_count, stall_cycles, first_valid_cyc, first_s1_cyc, last_hs_cyc;
    int done_cnt = 0, err_cnt = 0, err_cyc = 0;
    int wb_lat = 2, drop_idx = -1, hold_idx = -1, hold_extra = 0, last_due = 0, held_due = 0, due;
    int stall_left = 0;
    bit lat_rand = 0, ready_rand = 0;
    logic prev_stall = 1'b0;
    logic [2:0] prev_a, prev_b;
    logic [1:0] prev_stage;
    logic [63:0] prev_rom;

    // Reference model: stage s, butterfly b straight from the radix-2 DIT index rules.
    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            desc_t d;
            int span, b;
            d.s  = i / 4;
            b    = i % 4;
            span = 1 << d.s;
            d.a  = ((b >> d.s) << (d.s + 1)) | (b & (span - 1));
            d.b  = d.a + span;
            d.k  = (b & (span - 1)) << (2 - d.s);
            exp_q.push_back(d);
        end
    endtask

    // Input drivers: act 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && m_valid && m_stage == 2'd2 && m_a == 3'd1) begin
            bf_ready = 1'b0;
            stall_left--;
        end else if (ready_rand) begin
            bf_ready = ($urandom_range(3, 0) != 0);
        end else begin
            bf_ready = 1'b1;
        end
        wb_valid = wb_force;
        if (wb_q.size() > 0 && wb_q[0] == cyc) begin
            wb_valid = 1'b1;
            void'(wb_q.pop_front());
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_done) done_cnt++;
            if (m_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_stage == 2'd1 && first_s1_cyc < 0) first_s1_cyc = cyc;
            if (prev_stall) begin
                check("stall_hold_valid", m_valid, 1);
                check("stall_hold_idx_a", m_a, prev_a);
                check("stall_hold_idx_b", m_b, prev_b);
                check("stall_hold_stage", m_stage, prev_stage);
                check("stall_hold_rom", rom_q, prev_rom);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_descriptor: got a=%0d b=%0d stage=%0d, expected none", m_a, m_b, m_stage);
                end else begin
                    cur = exp_q[0];
                    if (!bf_ready) begin
                        stall_cycles++;
                        check("stall_tw_addr", m_tw, cur.k);
                    end else begin
                        void'(exp_q.pop_front());
                        check("idx_a", m_a, cur.a);
                        check("idx_b", m_b, cur.b);
                        check("stage", m_stage, cur.s);
                        check("rom_w", rom_q, rom_lookup(2'(cur.k)));
                        if (hs_count != drop_idx) begin
                            if (lat_rand) due = cyc + int'($urandom_range(4, 1));
                            else          due = cyc + wb_lat;
                            if (hs_count == hold_idx) due += hold_extra;
                            if (due <= last_due) due = last_due + 1;
                            last_due = due;
                            wb_q.push_back(due);
                            if (hs_count == hold_idx) held_due = due;
                        end
                        last_hs_cyc = cyc;
                        hs_count++;
                    end
                end
            end
            prev_stall = m_valid && !bf_ready;
            prev_a     = m_a;
            prev_b     = m_b;
            prev_stage = m_stage;
            prev_rom   = rom_q;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_done"}, m_done, 0);
        check({tag, "_err"}, m_err, 0);
        check({tag, "_bf_valid"}, m_valid, 0);
        check({tag, "_idx_a"}, m_a, 0);
        check({tag, "_idx_b"}, m_b, 0);
        check({tag, "_stage"}, m_stage, 0);
        check({tag, "_tw_addr"}, m_tw, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; wb_force = 1'b0; stall_left = 0; drop_idx = -1; hold_idx = -1;
        hold_extra = 0; lat_rand = 0; wb_lat = 2; ready_rand = 0;
        exp_q.delete(); wb_q.delete(); prev_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic begin_run(input int n_desc);
        exp_q.delete(); wb_q.delete(); push_run(n_desc);
        hs_count = 0; stall_cycles = 0; first_valid_cyc = -1; first_s1_cyc = -1; last_due = 0;
    endtask

    task automatic run_fft(input string tag, input int n_desc, input bit expect_done);
        int c0, done0, err0;
        begin_run(n_desc);
        done0 = done_cnt;
        err0  = err_cnt;
        @(posedge clk); #1 start = 1'b1; c0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy_after_start"}, m_busy, 1);
        for (int i = 0; i < 600 && done_cnt == done0 && err_cnt == err0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - done0, expect_done ? 1 : 0);
        check({tag, "_err_pulses"}, err_cnt - err0, expect_done ? 0 : 1);
        check({tag, "_busy_end"}, m_busy, 0);
        check({tag, "_descriptors_left"}, exp_q.size(), 0);
        check({tag, "_first_valid_latency"}, first_valid_cyc - c0, 2);
    endtask

    initial begin
        int done0, err0;
        #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        do_reset();

        run_fft("full", 12, 1'b1);

        for (int r = 0; r < 3; r++) begin
            ready_rand = 1; lat_rand = 1;
            run_fft("random", 12, 1'b1);
        end
        ready_rand = 0; lat_rand = 0; wb_lat = 2;

        stall_left = 3;
        run_fft("backpressure", 12, 1'b1);
        check("backpressure_stall_cycles", stall_cycles, 3);

        hold_idx = 3; hold_extra = 10;
        run_fft("barrier", 12, 1'b1);
        check("barrier_resume_cycle", first_s1_cyc, held_due + 1);
        hold_idx = -1; hold_extra = 0;

        do_reset();
        sel = 1'b1; drop_idx = 5;
        run_fft("timeout", 8, 1'b0);
        check("timeout_err_cycle", err_cyc - last_hs_cyc, 9);
        sel = 1'b0;
        do_reset();

        err0 = err_cnt;
        @(negedge clk) wb_force = 1'b1;
        @(negedge clk) wb_force = 1'b0;
        @(posedge clk); #2;
        check("stray_err_high", m_err, 1);
        check("stray_busy", m_busy, 0);
        check("stray_no_valid", m_valid, 0);
        @(posedge clk); #2;
        check("stray_err_low", m_err, 0);
        @(negedge clk);
        check("stray_err_pulses", err_cnt - err0, 1);

        wb_lat = 1;
        run_fft("simultaneous", 12, 1'b1);
        wb_lat = 2;

        begin_run(12);
        done0 = done_cnt;
        err0  = err_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200 && hs_count < 6; i++) @(negedge clk);
        check("midrst_handshakes", hs_count, 6);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_q.delete(); wb_q.delete(); prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_no_done", done_cnt - done0, 0);
        check("midrst_no_err", err_cnt - err0, 0);
        run_fft("after_reset", 12, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
